// File: rtl/regbank_pkg.sv
// Shared constants for the banked register-bank arbiter: ARM mode encodings,
// architectural register numbers, physical bank indices and FSM states.
package regbank_pkg;

  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [4:0] MODE_ABT = 5'b10111;
  localparam logic [4:0] MODE_UND = 5'b11011;
  localparam logic [4:0] MODE_SYS = 5'b11111;

  localparam logic [4:0] ADDR_R13  = 5'd13;
  localparam logic [4:0] ADDR_R14  = 5'd14;
  localparam logic [4:0] ADDR_R15  = 5'd15;
  localparam logic [4:0] ADDR_CPSR = 5'd16;
  localparam logic [4:0] ADDR_SPSR = 5'd17;

  localparam logic [5:0] IDX_R8_FIQ   = 6'd16;
  localparam logic [5:0] IDX_R13_USR  = 6'd13;
  localparam logic [5:0] IDX_R13_FIQ  = 6'd21;
  localparam logic [5:0] IDX_R13_SVC  = 6'd23;
  localparam logic [5:0] IDX_R13_ABT  = 6'd25;
  localparam logic [5:0] IDX_R13_IRQ  = 6'd27;
  localparam logic [5:0] IDX_R13_UND  = 6'd29;
  localparam logic [5:0] IDX_CPSR     = 6'd31;
  localparam logic [5:0] IDX_SPSR_FIQ = 6'd32;
  localparam logic [5:0] IDX_SPSR_SVC = 6'd33;
  localparam logic [5:0] IDX_SPSR_ABT = 6'd34;
  localparam logic [5:0] IDX_SPSR_IRQ = 6'd35;
  localparam logic [5:0] IDX_SPSR_UND = 6'd36;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/regbank_arbiter_if.sv
// Requester handshake, tagged response and register-bank port bundle.
// slave = arbiter side, master = requesters plus bank side.
interface regbank_arbiter_if #(
  parameter int NREQ = 3,
  parameter int DW   = 32
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_we;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*5-1:0]  req_addr;
  logic [NREQ*5-1:0]  req_mode;
  logic [NREQ*DW-1:0] req_wdata;

  logic               resp_valid;
  logic [IDW-1:0]     resp_id;
  logic               resp_err;
  logic [DW-1:0]      resp_rdata;

  logic               bank_en;
  logic               bank_we;
  logic [5:0]         bank_addr;
  logic [DW-1:0]      bank_wdata;
  logic [DW-1:0]      bank_rdata;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_mode, req_wdata, bank_rdata,
    output req_ready, resp_valid, resp_id, resp_err, resp_rdata,
           bank_en, bank_we, bank_addr, bank_wdata
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_mode, req_wdata, bank_rdata,
    input  req_ready, resp_valid, resp_id, resp_err, resp_rdata,
           bank_en, bank_we, bank_addr, bank_wdata
  );

endinterface

// File: rtl/regbank_addr_map.sv
// Architectural register number + ARM mode -> physical bank index (0-36).
// Illegal address or mode yields err=1 and idx=0.
module regbank_addr_map
  import regbank_pkg::*;
(
  input  logic [4:0] addr,
  input  logic [4:0] mode,
  output logic [5:0] idx,
  output logic       err
);

  logic       mode_ok;
  logic       is_fiq;
  logic       spsr_ok;
  logic [5:0] r13_base;
  logic [5:0] spsr_idx;

  // Decode the mode into its banked R13 base and SPSR slot
  always_comb begin
    mode_ok  = 1'b1;
    is_fiq   = 1'b0;
    spsr_ok  = 1'b1;
    r13_base = IDX_R13_USR;
    spsr_idx = '0;
    case (mode)
      MODE_FIQ: begin is_fiq = 1'b1; r13_base = IDX_R13_FIQ; spsr_idx = IDX_SPSR_FIQ; end
      MODE_SVC: begin r13_base = IDX_R13_SVC; spsr_idx = IDX_SPSR_SVC; end
      MODE_ABT: begin r13_base = IDX_R13_ABT; spsr_idx = IDX_SPSR_ABT; end
      MODE_IRQ: begin r13_base = IDX_R13_IRQ; spsr_idx = IDX_SPSR_IRQ; end
      MODE_UND: begin r13_base = IDX_R13_UND; spsr_idx = IDX_SPSR_UND; end
      MODE_USR, MODE_SYS: spsr_ok = 1'b0;
      default: begin mode_ok = 1'b0; spsr_ok = 1'b0; end
    endcase
  end

  // Map the register number using the decoded mode
  always_comb begin
    idx = '0;
    err = 1'b0;
    if (addr <= 5'd7 || addr == ADDR_R15) begin
      idx = {1'b0, addr};
    end else if (addr <= 5'd12) begin
      idx = is_fiq ? ({1'b0, addr} + (IDX_R8_FIQ - 6'd8)) : {1'b0, addr};
    end else if (addr == ADDR_R13 || addr == ADDR_R14) begin
      idx = r13_base + {5'd0, addr == ADDR_R14};
    end else if (addr == ADDR_CPSR) begin
      idx = IDX_CPSR;
    end else if (addr == ADDR_SPSR) begin
      idx = spsr_idx;
      err = !spsr_ok;
    end else begin
      err = 1'b1;
    end
    if (!mode_ok) err = 1'b1;
    if (err) idx = '0;
  end

endmodule

// File: rtl/regbank_arbiter.sv
// Round-robin arbiter sharing the single-ported banked register bank between
// NREQ requesters. One transaction at a time: IDLE (grant) -> ISSUE -> RESP.
// Optional grant locking is built when REGBANK_ARBITER_LOCK_EN is defined.
module regbank_arbiter
  import regbank_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = 32
)(
  input  logic              clk,
  input  logic              rst_n,
  regbank_arbiter_if.slave  bus,
  output logic              busy
);

  localparam int IDW = $clog2(NREQ);

  state_e          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d;
  logic [IDW-1:0]  id_q, id_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic [5:0]      idx_q, idx_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic            has_win;
  int unsigned     win_sel;
  logic [IDW-1:0]  win;
  logic [NREQ-1:0] ready;
  logic [4:0]      win_addr, win_mode;
  logic [5:0]      map_idx;
  logic            map_err;

`ifdef REGBANK_ARBITER_LOCK_EN
  logic            lock_q, lock_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic            lk_q, lk_d;
`else
  logic            unused_lock;
  assign unused_lock = ^bus.req_lock;
`endif

  // Pick the first valid requester after the rr pointer; a lock owner overrides
  always_comb begin
    has_win = 1'b0;
    win_sel = 0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      if (!has_win && bus.req_valid[(32'(rr_q) + i) % NREQ]) begin
        has_win = 1'b1;
        win_sel = (32'(rr_q) + i) % NREQ;
      end
    end
`ifdef REGBANK_ARBITER_LOCK_EN
    if (lock_q) begin
      has_win = bus.req_valid[owner_q];
      win_sel = 32'(owner_q);
    end
`endif
    win      = IDW'(win_sel);
    win_addr = bus.req_addr[win_sel*5 +: 5];
    win_mode = bus.req_mode[win_sel*5 +: 5];
  end

  regbank_addr_map u_map (
    .addr (win_addr),
    .mode (win_mode),
    .idx  (map_idx),
    .err  (map_err)
  );

  // FSM next state, grant and transaction capture
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    id_d    = id_q;
    we_d    = we_q;
    err_d   = err_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    ready   = '0;
`ifdef REGBANK_ARBITER_LOCK_EN
    lock_d  = lock_q;
    owner_d = owner_q;
    lk_d    = lk_q;
`endif
    case (state_q)
      IDLE: begin
        if (has_win) begin
          ready[win_sel] = 1'b1;
          state_d = ISSUE;
          id_d    = win;
          we_d    = bus.req_we[win_sel];
          err_d   = map_err;
          idx_d   = map_idx;
          wdata_d = bus.req_wdata[win_sel*DW +: DW];
          rr_d    = win;
`ifdef REGBANK_ARBITER_LOCK_EN
          if (lock_q) rr_d = rr_q;
          lk_d = bus.req_lock[win_sel];
          if (bus.req_lock[win_sel]) begin
            lock_d  = 1'b1;
            owner_d = win;
          end
`endif
        end
      end
      ISSUE: state_d = RESP;
      RESP: begin
        state_d = IDLE;
`ifdef REGBANK_ARBITER_LOCK_EN
        // While locked every transaction is the owner's, so lk_q=0 means release
        if (lock_q && !lk_q) lock_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and transaction registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= IDW'(NREQ - 1);
      id_q    <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
`ifdef REGBANK_ARBITER_LOCK_EN
      lock_q  <= 1'b0;
      owner_q <= '0;
      lk_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      id_q    <= id_d;
      we_q    <= we_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
`ifdef REGBANK_ARBITER_LOCK_EN
      lock_q  <= lock_d;
      owner_q <= owner_d;
      lk_q    <= lk_d;
`endif
    end
  end

  // Outputs decoded from registered state, so reset clears them immediately
  assign bus.req_ready  = ready;
  assign bus.bank_en    = (state_q == ISSUE) && !err_q;
  assign bus.bank_we    = (state_q == ISSUE) && we_q && !err_q;
  assign bus.bank_addr  = (state_q == ISSUE) ? idx_q : '0;
  assign bus.bank_wdata = (state_q == ISSUE) ? wdata_q : '0;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_id    = (state_q == RESP) ? id_q : '0;
  assign bus.resp_err   = (state_q == RESP) && err_q;
  assign bus.resp_rdata = ((state_q == RESP) && !we_q && !err_q) ? bus.bank_rdata : '0;
  assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed self-checking bench for regbank_arbiter with a 37-entry bank model.
module tb_regbank_arbiter;
  import regbank_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   n_checks = 0;
  int   n_errors = 0;

  regbank_arbiter_if #(.NREQ(3), .DW(32)) bus ();

  regbank_arbiter #(.NREQ(3), .DW(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Bank model: initialised on the first edge, read data valid the cycle after bank_en
  logic [31:0] mem [0:36];
  logic [31:0] bank_rdata_q = 32'hA5A5_A5A5;
  logic        init_done = 1'b0;
  assign bus.bank_rdata = bank_rdata_q;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 37; i++) mem[i] <= 32'hDEAD_0000 | i;
      init_done <= 1'b1;
    end else if (bus.bank_en) begin
      if (bus.bank_we) mem[bus.bank_addr] <= bus.bank_wdata;
      else             bank_rdata_q <= mem[bus.bank_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic we, input logic lock,
                         input logic [4:0] addr, input logic [4:0] mode, input logic [31:0] wdata);
    bus.req_valid[r]          = v;
    bus.req_we[r]             = we;
    bus.req_lock[r]           = lock;
    bus.req_addr[r*5 +: 5]    = addr;
    bus.req_mode[r*5 +: 5]    = mode;
    bus.req_wdata[r*32 +: 32] = wdata;
  endtask

  task automatic clear_reqs();
    for (int r = 0; r < 3; r++) set_req(r, 1'b0, 1'b0, 1'b0, 5'd0, MODE_USR, 32'd0);
  endtask

  // Returns at a negedge with rst_n just released
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_reqs();
    @(negedge clk);
    #1;
    check_eq("rst_ready", 32'(bus.req_ready), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("rst_bank_en", 32'(bus.bank_en), 32'd0);
    check_eq("rst_resp_rdata", bus.resp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_txn(input string tag, input int r, input logic we, input logic [4:0] addr,
                        input logic [4:0] mode, input logic [31:0] wdata, input logic [5:0] exp_idx,
                        input logic exp_err, input logic [31:0] exp_rdata);
    int cnt;
    @(negedge clk);
    set_req(r, 1'b1, we, 1'b0, addr, mode, wdata);
    #1;
    cnt = 0;
    while (!bus.req_ready[r] && cnt < 20) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check_eq({tag, "_ready"}, 32'(bus.req_ready), 32'(1 << r));
    @(posedge clk);
    #1;
    bus.req_valid[r] = 1'b0;
    @(negedge clk);
    check_eq({tag, "_bank_en"}, 32'(bus.bank_en), 32'(!exp_err));
    check_eq({tag, "_bank_we"}, 32'(bus.bank_we), 32'(we && !exp_err));
    if (!exp_err) check_eq({tag, "_bank_addr"}, 32'(bus.bank_addr), 32'(exp_idx));
    if (we && !exp_err) check_eq({tag, "_bank_wdata"}, bus.bank_wdata, wdata);
    @(negedge clk);
    check_eq({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
    check_eq({tag, "_resp_id"}, 32'(bus.resp_id), 32'(r));
    check_eq({tag, "_resp_err"}, 32'(bus.resp_err), 32'(exp_err));
    check_eq({tag, "_resp_rdata"}, bus.resp_rdata, exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    clear_reqs();
    apply_reset();

    // Basic read, banked R13 writes, mapping corners
    do_txn("rd_r3",     0, 1'b0, 5'd3,  MODE_USR, 32'd0,      6'd3,  1'b0, 32'hDEAD_0003);
    do_txn("wr_r13_svc", 0, 1'b1, 5'd13, MODE_SVC, 32'h1000,  6'd23, 1'b0, 32'd0);
    do_txn("wr_r13_fiq", 0, 1'b1, 5'd13, MODE_FIQ, 32'h1000,  6'd21, 1'b0, 32'd0);
    do_txn("wr_r13_usr", 0, 1'b1, 5'd13, MODE_USR, 32'h1000,  6'd13, 1'b0, 32'd0);
    do_txn("rd_r13_svc", 2, 1'b0, 5'd13, MODE_SVC, 32'd0,     6'd23, 1'b0, 32'h1000);
    do_txn("rd_r14_und", 1, 1'b0, 5'd14, MODE_UND, 32'd0,     6'd30, 1'b0, 32'hDEAD_001E);
    do_txn("rd_r10_fiq", 2, 1'b0, 5'd10, MODE_FIQ, 32'd0,     6'd18, 1'b0, 32'hDEAD_0012);
    do_txn("rd_r10_usr", 0, 1'b0, 5'd10, MODE_USR, 32'd0,     6'd10, 1'b0, 32'hDEAD_000A);
    do_txn("rd_cpsr",    1, 1'b0, 5'd16, MODE_SYS, 32'd0,     6'd31, 1'b0, 32'hDEAD_001F);
    do_txn("rd_spsr_irq", 2, 1'b0, 5'd17, MODE_IRQ, 32'd0,    6'd35, 1'b0, 32'hDEAD_0023);
    do_txn("rd_r15_fiq", 0, 1'b0, 5'd15, MODE_FIQ, 32'd0,     6'd15, 1'b0, 32'hDEAD_000F);
    do_txn("rd_r13_abt", 1, 1'b0, 5'd13, MODE_ABT, 32'd0,     6'd25, 1'b0, 32'hDEAD_0019);

    // Error cases
    do_txn("err_spsr_usr", 0, 1'b0, 5'd17, MODE_USR, 32'd0,   6'd0, 1'b1, 32'd0);
    do_txn("err_addr20",   1, 1'b0, 5'd20, MODE_SVC, 32'd0,   6'd0, 1'b1, 32'd0);
    do_txn("err_mode",     2, 1'b0, 5'd0,  5'b10100, 32'd0,   6'd0, 1'b1, 32'd0);

    // Round robin with all requesters held valid from reset
    apply_reset();
    for (int r = 0; r < 3; r++) set_req(r, 1'b1, 1'b0, 1'b0, 5'd0, MODE_USR, 32'd0);
    #1;
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("rr_grant%0d", k), 32'(bus.req_ready), 32'(1 << (k % 3)));
      @(negedge clk);
      #1;
      check_eq($sformatf("rr_busy%0d", k), 32'(busy), 32'd1);
      @(negedge clk);
      if (k == 4) begin
        bus.req_valid[0] = 1'b0;
        bus.req_valid[2] = 1'b0;
      end
      #1;
      @(negedge clk);
      #1;
    end
    check_eq("rr_only1_a", 32'(bus.req_ready), 32'b010);
    repeat (3) @(negedge clk);
    #1;
    check_eq("rr_only1_b", 32'(bus.req_ready), 32'b010);

    // Reset during ISSUE of a write by requester 1
    apply_reset();
    set_req(1, 1'b1, 1'b1, 1'b0, 5'd5, MODE_USR, 32'h0000_0055);
    #1;
    check_eq("ab_ready", 32'(bus.req_ready), 32'b010);
    @(posedge clk);
    #1;
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    #1;
    check_eq("ab_bank_en_pre", 32'(bus.bank_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("ab_bank_en_post", 32'(bus.bank_en), 32'd0);
    check_eq("ab_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check_eq("ab_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_eq("ab_no_write", mem[5], 32'hDEAD_0005);
    rst_n = 1'b1;
    for (int r = 0; r < 3; r++) set_req(r, 1'b1, 1'b0, 1'b0, 5'd0, MODE_USR, 32'd0);
    #1;
    check_eq("ab_next_grant", 32'(bus.req_ready), 32'b001);

    // Lock: requester 2 locks on a CPSR read, then writes CPSR with lock released
    apply_reset();
    set_req(2, 1'b1, 1'b0, 1'b1, 5'd16, MODE_SVC, 32'd0);
    #1;
    check_eq("lk_grant2", 32'(bus.req_ready), 32'b100);
    @(posedge clk);
    #1;
    set_req(0, 1'b1, 1'b0, 1'b0, 5'd0, MODE_USR, 32'd0);
    set_req(1, 1'b1, 1'b0, 1'b0, 5'd1, MODE_USR, 32'd0);
    set_req(2, 1'b1, 1'b1, 1'b0, 5'd16, MODE_SVC, 32'h6000_00D3);
    @(negedge clk);
    check_eq("lk_bank_addr", 32'(bus.bank_addr), 32'd31);
    @(negedge clk);
    check_eq("lk_resp_rdata", bus.resp_rdata, 32'hDEAD_001F);
    @(negedge clk);
    #1;
`ifdef REGBANK_ARBITER_LOCK_EN
    check_eq("lk_next_grant", 32'(bus.req_ready), 32'b100);
    @(posedge clk);
    #1;
    bus.req_valid[2] = 1'b0;
    @(negedge clk);
    check_eq("lk_wr_we", 32'(bus.bank_we), 32'd1);
    check_eq("lk_wr_wdata", bus.bank_wdata, 32'h6000_00D3);
    @(negedge clk);
    check_eq("lk_wr_resp_id", 32'(bus.resp_id), 32'd2);
    @(negedge clk);
    #1;
    check_eq("lk_after_release", 32'(bus.req_ready), 32'b001);
`else
    check_eq("lk_next_grant", 32'(bus.req_ready), 32'b001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
